// File: rtl/ram_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_dump_pkg
// Purpose  : Shared definitions for the RAM dump / UART readout stage.
//            Holds the sequencer state encoding, the default header byte
//            and the UART frame length in bit periods.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ram_dump_pkg;

  // One UART frame is start + 8 data + stop bit periods.
  localparam int C_FRAME_LEN = 10;

  localparam logic [7:0] C_DEFAULT_SYNC_BYTE = 8'hA5;

  // One-hot sequencer states, in the same style as the capture stage.
  typedef enum logic [6:0] {
    ST_IDLE  = 7'b0000001,
    ST_HDR   = 7'b0000010,
    ST_RD_LO = 7'b0000100,
    ST_TX_LO = 7'b0001000,
    ST_RD_HI = 7'b0010000,
    ST_TX_HI = 7'b0100000,
    ST_NEXT  = 7'b1000000
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ram_dump_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_byte
// Purpose  : 8N1 UART transmitter for a single byte. A load pulse captures
//            the byte; the start bit appears on the following cycle and
//            every bit lasts CLK_DIV cycles.
// Ports    : CLK     - clock, rising edge
//            reset   - synchronous active-high reset
//            load    - capture data and start a frame (ignored-safe only
//                      when idle)
//            data    - byte to send, LSB first
//            txd     - serial line, idle high
//            tx_done - one-cycle pulse in the last cycle of the stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_byte
  import ram_dump_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       txd,
  output logic       tx_done
);

  localparam int C_BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [C_BAUD_W-1:0] baud_q;
  logic [3:0]          bit_q;     // index of the bit currently on the line
  logic [7:0]          shift_q;   // remaining data bits, next one in [0]
  logic                active_q;
  logic                txd_q;

  logic w_baud_end;
  logic w_last_bit;

  assign w_baud_end = (baud_q == C_BAUD_W'(CLK_DIV - 1));
  assign w_last_bit = (bit_q == 4'(C_FRAME_LEN - 1));

  always_ff @(posedge CLK) begin
    if (reset) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      active_q <= 1'b0;
      txd_q    <= 1'b1;
    end else if (load) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= data;
      active_q <= 1'b1;
      txd_q    <= 1'b0;
    end else if (active_q) begin
      if (w_baud_end) begin
        baud_q <= '0;
        if (w_last_bit) begin
          active_q <= 1'b0;
          txd_q    <= 1'b1;
        end else begin
          bit_q <= bit_q + 4'd1;
          // Bit index 8 is the last data bit; the next one is the stop bit.
          if (bit_q == 4'(C_FRAME_LEN - 2)) begin
            txd_q <= 1'b1;
          end else begin
            txd_q   <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end
        end
      end else begin
        baud_q <= baud_q + C_BAUD_W'(1);
      end
    end
  end

  assign txd     = txd_q;
  assign tx_done = active_q & w_baud_end & w_last_bit;

endmodule
`default_nettype wire

// File: rtl/ram_dump_uart.sv
`default_nettype none
// ============================================================================
// Module   : ram_dump_uart
// Purpose  : Reads N_WORDS 16-bit words from the result RAM (low and high
//            byte lanes) and sends them over an 8N1 UART, preceded by one
//            sync byte. Low byte of each word is sent first.
// Ports    : CLK     - clock, rising edge
//            reset   - synchronous active-high reset
//            start   - begin a dump (sampled only while idle)
//            indata  - RAM byte data bus
//            address - RAM word address
//            nrd1    - active-low read enable, low-byte lane
//            nrd2    - active-low read enable, high-byte lane
//            txd     - UART serial output, idle high
//            busy    - dump in progress
//            done    - one-cycle pulse after the last stop bit
// Revision : 1.0 - initial release
// ============================================================================
module ram_dump_uart
  import ram_dump_pkg::*;
#(
  parameter int         CLK_DIV   = 434,
  parameter int         N_WORDS   = 2048,
  parameter int         ADDR_W    = 11,
  parameter int         RD_WAIT   = 2,
  parameter logic [7:0] SYNC_BYTE = C_DEFAULT_SYNC_BYTE
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        indata,
  output logic [ADDR_W-1:0] address,
  output logic              nrd1,
  output logic              nrd2,
  output logic              txd,
  output logic              busy,
  output logic              done
);

  localparam int C_WAIT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [C_WAIT_W-1:0] wait_q, wait_d;

  logic       w_tx_load;
  logic [7:0] w_tx_data;
  logic       w_tx_done;
  logic       w_last_wait;
  logic       w_last_word;

  assign w_last_wait = (wait_q == C_WAIT_W'(RD_WAIT - 1));
  assign w_last_word = (addr_q == ADDR_W'(N_WORDS - 1));

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wait_d    = wait_q;
    w_tx_load = 1'b0;
    w_tx_data = indata;
    done      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Header frame starts on the very next cycle.
          addr_d    = '0;
          w_tx_load = 1'b1;
          w_tx_data = SYNC_BYTE;
          state_d   = ST_HDR;
        end
      end
      ST_HDR: begin
        if (w_tx_done) state_d = ST_RD_LO;
      end
      ST_RD_LO: begin
        // The transmitter's shift register is the byte register: loading
        // it on the last strobe cycle samples indata at that edge.
        if (w_last_wait) begin
          wait_d    = '0;
          w_tx_load = 1'b1;
          state_d   = ST_TX_LO;
        end else begin
          wait_d = wait_q + C_WAIT_W'(1);
        end
      end
      ST_TX_LO: begin
        if (w_tx_done) state_d = ST_RD_HI;
      end
      ST_RD_HI: begin
        if (w_last_wait) begin
          wait_d    = '0;
          w_tx_load = 1'b1;
          state_d   = ST_TX_HI;
        end else begin
          wait_d = wait_q + C_WAIT_W'(1);
        end
      end
      ST_TX_HI: begin
        if (w_tx_done) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if (w_last_word) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_RD_LO;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  uart_tx_byte #(
    .CLK_DIV (CLK_DIV)
  ) u_tx (
    .CLK     (CLK),
    .reset   (reset),
    .load    (w_tx_load),
    .data    (w_tx_data),
    .txd     (txd),
    .tx_done (w_tx_done)
  );

  // Strobes decode straight from the one-hot state register, so the two
  // lanes can never be enabled together.
  assign nrd1    = (state_q != ST_RD_LO);
  assign nrd2    = (state_q != ST_RD_HI);
  assign busy    = (state_q != ST_IDLE);
  assign address = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_dump_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dump_uart
// Purpose  : Self-checking bench for ram_dump_uart with CLK_DIV=4,
//            N_WORDS=4, RD_WAIT=2. A cycle-indexed model derives every
//            output from the dump timeline; a UART decoder recovers the
//            byte stream for comparison with hand-computed literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dump_uart;

  localparam int CLK_DIV  = 4;
  localparam int N_WORDS  = 4;
  localparam int ADDR_W   = 2;
  localparam int RD_WAIT  = 2;
  localparam logic [7:0] SYNC = 8'hA5;

  localparam int FRAME    = 10 * CLK_DIV;
  localparam int WORD_LEN = 2 * RD_WAIT + 2 * FRAME + 1;
  localparam int TOTAL    = FRAME + N_WORDS * WORD_LEN;   // 380

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        indata;
  logic [ADDR_W-1:0] address;
  logic              nrd1, nrd2, txd, busy, done;

  logic [15:0] ram [N_WORDS];
  logic [7:0]  exp_bytes [9];

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  n_done = 0;
  int  t_acc;
  bit  chk_en = 1'b0;

  // model state
  bit  m_active = 1'b0;
  int  m_k = 0;
  int  m_last_addr = 0;

  logic [7:0] rx [$];
  logic [7:0] dec_b;

  ram_dump_uart #(
    .CLK_DIV   (CLK_DIV),
    .N_WORDS   (N_WORDS),
    .ADDR_W    (ADDR_W),
    .RD_WAIT   (RD_WAIT),
    .SYNC_BYTE (SYNC)
  ) dut (
    .CLK     (clk),
    .reset   (reset),
    .start   (start),
    .indata  (indata),
    .address (address),
    .nrd1    (nrd1),
    .nrd2    (nrd2),
    .txd     (txd),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  assign indata = !nrd1 ? ram[address][7:0] :
                  !nrd2 ? ram[address][15:8] : 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  always @(posedge clk) cyc++;

  // Timeline model: m_k is the cycle number counted from the accepting edge.
  always @(posedge clk) begin
    if (reset) begin
      m_active    = 1'b0;
      m_k         = 0;
      m_last_addr = 0;
    end else if (m_active) begin
      if (m_k == TOTAL) begin
        m_active    = 1'b0;
        m_last_addr = N_WORDS - 1;
      end else begin
        m_k++;
      end
    end else if (start) begin
      m_active = 1'b1;
      m_k      = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic e_busy, e_done, e_nrd1, e_nrd2, e_txd;
      int   e_addr, j, w;
      e_busy = m_active; e_done = 1'b0; e_nrd1 = 1'b1; e_nrd2 = 1'b1; e_txd = 1'b1;
      e_addr = m_last_addr;
      if (m_active) begin
        if (m_k <= FRAME) begin
          e_addr = 0;
          e_txd  = frame_bit(SYNC, (m_k - 1) / CLK_DIV);
        end else begin
          j = (m_k - FRAME - 1) % WORD_LEN;
          w = (m_k - FRAME - 1) / WORD_LEN;
          e_addr = w;
          if (j < RD_WAIT) e_nrd1 = 1'b0;
          else if (j < RD_WAIT + FRAME)
            e_txd = frame_bit(ram[w][7:0], (j - RD_WAIT) / CLK_DIV);
          else if (j < 2 * RD_WAIT + FRAME) e_nrd2 = 1'b0;
          else if (j < 2 * RD_WAIT + 2 * FRAME)
            e_txd = frame_bit(ram[w][15:8], (j - 2 * RD_WAIT - FRAME) / CLK_DIV);
          else if (w == N_WORDS - 1) e_done = 1'b1;
        end
      end
      check("busy", busy, e_busy);
      check("done", done, e_done);
      check("nrd1", nrd1, e_nrd1);
      check("nrd2", nrd2, e_nrd2);
      check("txd", txd, e_txd);
      check("address", address, e_addr);
      check("strobe_overlap", nrd1 | nrd2, 1);
    end
  end

  always @(negedge clk) if (chk_en && done === 1'b1) n_done++;

  // UART receiver sampling mid-bit.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && txd === 1'b0) begin
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          dec_b[i] = txd;
        end
        repeat (CLK_DIV) @(negedge clk);
        rx.push_back(dec_b);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    t_acc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got no done, expected done within 2000 cycles");
    end else begin
      check("done_latency", cyc - t_acc, TOTAL);
    end
  endtask

  task automatic check_stream(input int reps);
    check("rx_len", rx.size(), 9 * reps);
    for (int i = 0; i < 9 * reps; i++) begin
      if (i < rx.size()) check("rx_byte", rx[i], exp_bytes[i % 9]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    ram[0] = 16'h1234; ram[1] = 16'h00FF; ram[2] = 16'hABCD; ram[3] = 16'h8001;
    exp_bytes = '{8'hA5, 8'h34, 8'h12, 8'hFF, 8'h00, 8'hCD, 8'hAB, 8'h01, 8'h80};
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_nrd1", nrd1, 1);
    check("rst_nrd2", nrd2, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", address, 0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Basic dump
    rx.delete();
    pulse_start();
    wait_done();
    repeat (5) @(negedge clk);
    check_stream(1);
    check("hold_addr", address, 3);

    // Ignored start pulses during a dump
    rx.delete();
    d0 = n_done;
    pulse_start();
    repeat (48) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (149) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_done();
    repeat (5) @(negedge clk);
    check("one_done", n_done - d0, 1);
    check_stream(1);

    // Reset in the middle of word 1's high-byte data bits
    rx.delete();
    pulse_start();
    repeat (178) @(negedge clk);
    d0 = n_done;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_txd", txd, 1);
    check("midrst_nrd1", nrd1, 1);
    check("midrst_nrd2", nrd2, 1);
    check("midrst_addr", address, 0);
    check("midrst_busy", busy, 0);
    repeat (60) @(negedge clk);
    check("midrst_no_done", n_done - d0, 0);
    rx.delete();
    pulse_start();
    wait_done();
    repeat (5) @(negedge clk);
    check_stream(1);

    // Back-to-back dumps
    rx.delete();
    pulse_start();
    wait_done();
    pulse_start();
    check("b2b_addr", address, 0);
    check("b2b_busy", busy, 1);
    wait_done();
    repeat (5) @(negedge clk);
    check_stream(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
